// File: rtl/machine_preloader.sv
// Command-driven preloader for the single-cycle machine: writes RF/memory words
// while the machine is held in reset, then releases it and counts run cycles until halt.
module machine_preloader #(
    parameter int          MAX_CYCLES = 64,
    parameter int          CYCLE_W    = 16,
    parameter logic [31:0] DATA_BASE  = 32'h4000,
    parameter int          DATA_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [31:0]        cmd_addr,
    input  logic [31:0]        cmd_data,
    output logic               rf_wr_en,
    output logic [4:0]         rf_wr_addr,
    output logic [31:0]        rf_wr_data,
    output logic               mem_wr_en,
    output logic [31:0]        mem_wr_addr,
    output logic [31:0]        mem_wr_data,
    output logic               cpu_reset,
    input  logic [31:0]        cpu_inst,
    output logic               done,
    output logic               timed_out,
    output logic               err,
    output logic [CYCLE_W-1:0] cycle_count
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high in LOAD and HALT and low for the whole of RUN.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0]         OP_REG   = 2'b00;
    localparam logic [1:0]         OP_MEM   = 2'b01;
    localparam logic [1:0]         OP_START = 2'b10;
    localparam logic [32:0]        MEM_LO   = {1'b0, DATA_BASE};
    localparam logic [32:0]        MEM_HI   = MEM_LO + 33'(DATA_WORDS);
    localparam logic [31:0]        LAST_CYC = 32'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] CNT_SAT  = '1;

    state_t               state, state_n;
    logic                 cmd_ready_n, rf_wr_en_n, mem_wr_en_n, cpu_reset_n;
    logic                 done_n, timed_out_n, err_n;
    logic [4:0]           rf_wr_addr_n;
    logic [31:0]          rf_wr_data_n, mem_wr_addr_n, mem_wr_data_n;
    logic [CYCLE_W-1:0]   cycle_count_n;
    logic                 accept, mem_in_range;
    logic [31:0]          count_ext;

    assign accept       = cmd_valid && cmd_ready;
    assign mem_in_range = ({1'b0, cmd_addr} >= MEM_LO) && ({1'b0, cmd_addr} < MEM_HI);
    assign count_ext    = 32'(cycle_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            cmd_ready   <= 1'b1;
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_data  <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            cmd_ready   <= cmd_ready_n;
            rf_wr_en    <= rf_wr_en_n;
            rf_wr_addr  <= rf_wr_addr_n;
            rf_wr_data  <= rf_wr_data_n;
            mem_wr_en   <= mem_wr_en_n;
            mem_wr_addr <= mem_wr_addr_n;
            mem_wr_data <= mem_wr_data_n;
            cpu_reset   <= cpu_reset_n;
            done        <= done_n;
            timed_out   <= timed_out_n;
            err         <= err_n;
            cycle_count <= cycle_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        rf_wr_en_n    = 1'b0;
        rf_wr_addr_n  = rf_wr_addr;
        rf_wr_data_n  = rf_wr_data;
        mem_wr_en_n   = 1'b0;
        mem_wr_addr_n = mem_wr_addr;
        mem_wr_data_n = mem_wr_data;
        cpu_reset_n   = cpu_reset;
        done_n        = done;
        timed_out_n   = timed_out;
        err_n         = err;
        cycle_count_n = cycle_count;

        case (state)
            LOAD, HALT: begin
                if (accept) begin
                    case (cmd_op)
                        OP_REG: begin
                            // r0 is hard-wired in the machine, so writes to it are dropped quietly.
                            if (cmd_addr[31:5] != '0) begin
                                err_n = 1'b1;
                            end else if (cmd_addr[4:0] != 5'd0) begin
                                rf_wr_en_n   = 1'b1;
                                rf_wr_addr_n = cmd_addr[4:0];
                                rf_wr_data_n = cmd_data;
                            end
                        end
                        OP_MEM: begin
                            if (mem_in_range) begin
                                mem_wr_en_n   = 1'b1;
                                mem_wr_addr_n = cmd_addr;
                                mem_wr_data_n = cmd_data;
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        OP_START: begin
                            state_n       = RUN;
                            cpu_reset_n   = 1'b0;
                            cycle_count_n = '0;
                            done_n        = 1'b0;
                            timed_out_n   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // A zero instruction wins over budget expiry on the same edge.
                if (cpu_inst == 32'h0) begin
                    state_n     = HALT;
                    cpu_reset_n = 1'b1;
                    done_n      = 1'b1;
                    timed_out_n = 1'b0;
                end else if (count_ext == LAST_CYC) begin
                    state_n     = HALT;
                    cpu_reset_n = 1'b1;
                    done_n      = 1'b1;
                    timed_out_n = 1'b1;
                end else if (cycle_count != CNT_SAT) begin
                    cycle_count_n = cycle_count + 1'b1;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    assign cmd_ready_n = (state_n != RUN);

endmodule

// File: tb/tb_machine_preloader.sv
// Directed bench for machine_preloader: preload writes, zero-instruction and
// budget halts, illegal commands, and asynchronous reset during a run.
module tb_machine_preloader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        cpu_reset;
    logic [31:0] cpu_inst;
    logic        done;
    logic        timed_out;
    logic        err;
    logic [15:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    machine_preloader #(
        .MAX_CYCLES(64),
        .CYCLE_W   (16),
        .DATA_BASE (32'h4000),
        .DATA_WORDS(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .cpu_reset  (cpu_reset),
        .cpu_inst   (cpu_inst),
        .done       (done),
        .timed_out  (timed_out),
        .err        (err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    initial begin
        reset    = 1'b1;
        cpu_inst = 32'h1;
        idle();
        tick(2);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cycle_count", 32'(cycle_count), 32'd0);
        check("rst_mem_wr_addr", mem_wr_addr, 32'd0);
        reset = 1'b0;
        tick();

        // Back-to-back register writes, then start.
        drive(2'b00, 32'd2, 32'hFFFF_FFFB);
        tick();
        check("rf1_en", 32'(rf_wr_en), 32'd1);
        check("rf1_addr", 32'(rf_wr_addr), 32'd2);
        check("rf1_data", rf_wr_data, 32'hFFFF_FFFB);
        drive(2'b00, 32'd3, 32'd1);
        tick();
        check("rf2_en", 32'(rf_wr_en), 32'd1);
        check("rf2_addr", 32'(rf_wr_addr), 32'd3);
        check("rf2_data", rf_wr_data, 32'd1);
        drive(2'b10, 32'd0, 32'd0);
        tick();
        idle();
        check("start_rf_en", 32'(rf_wr_en), 32'd0);
        check("start_cpu_reset", 32'(cpu_reset), 32'd0);
        check("start_cmd_ready", 32'(cmd_ready), 32'd0);
        check("start_count", 32'(cycle_count), 32'd0);

        // Five nonzero instructions, then a zero instruction.
        tick(5);
        check("run5_count", 32'(cycle_count), 32'd5);
        check("run5_done", 32'(done), 32'd0);
        cpu_inst = 32'h0;
        tick();
        check("zh_done", 32'(done), 32'd1);
        check("zh_timed_out", 32'(timed_out), 32'd0);
        check("zh_count", 32'(cycle_count), 32'd5);
        check("zh_cpu_reset", 32'(cpu_reset), 32'd1);
        check("zh_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("zh_count_hold", 32'(cycle_count), 32'd5);

        // Memory and register writes from HALT, legal and illegal.
        drive(2'b01, 32'h4002, 32'hDEAD_BEEF);
        tick();
        check("mem_en", 32'(mem_wr_en), 32'd1);
        check("mem_addr", mem_wr_addr, 32'h4002);
        check("mem_data", mem_wr_data, 32'hDEAD_BEEF);
        check("mem_done_held", 32'(done), 32'd1);
        drive(2'b00, 32'd0, 32'h1234_5678);
        tick();
        check("mem_single_pulse", 32'(mem_wr_en), 32'd0);
        check("r0_no_strobe", 32'(rf_wr_en), 32'd0);
        check("r0_no_err", 32'(err), 32'd0);
        drive(2'b01, 32'h4004, 32'h5555_5555);
        tick();
        check("mem_oob_no_strobe", 32'(mem_wr_en), 32'd0);
        check("mem_oob_err", 32'(err), 32'd1);
        drive(2'b01, 32'h3FFF, 32'h5555_5555);
        tick();
        check("mem_low_no_strobe", 32'(mem_wr_en), 32'd0);
        drive(2'b00, 32'd32, 32'h7);
        tick();
        check("r32_no_strobe", 32'(rf_wr_en), 32'd0);
        check("r32_err", 32'(err), 32'd1);
        drive(2'b11, 32'd5, 32'd5);
        tick();
        idle();
        tick();
        check("err_sticky", 32'(err), 32'd1);
        check("nop_no_strobe", 32'(rf_wr_en), 32'd0);

        // Budget expiry: 63 counting edges then forced halt on the 64th.
        cpu_inst = 32'h1;
        drive(2'b10, 32'd0, 32'd0);
        tick();
        idle();
        check("restart_done", 32'(done), 32'd0);
        check("restart_count", 32'(cycle_count), 32'd0);
        tick(63);
        check("b63_count", 32'(cycle_count), 32'd63);
        check("b63_done", 32'(done), 32'd0);
        tick();
        check("to_done", 32'(done), 32'd1);
        check("to_timed_out", 32'(timed_out), 32'd1);
        check("to_count", 32'(cycle_count), 32'd63);
        check("to_cpu_reset", 32'(cpu_reset), 32'd1);

        // Zero instruction on the final budget edge takes priority.
        drive(2'b10, 32'd0, 32'd0);
        tick();
        idle();
        check("restart2_timed_out", 32'(timed_out), 32'd0);
        tick(63);
        cpu_inst = 32'h0;
        tick();
        check("prio_done", 32'(done), 32'd1);
        check("prio_timed_out", 32'(timed_out), 32'd0);
        check("prio_count", 32'(cycle_count), 32'd63);

        // Reset in the middle of a strobe cancels it.
        drive(2'b00, 32'd5, 32'hA5A5_A5A5);
        tick();
        idle();
        check("r5_en", 32'(rf_wr_en), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_strobe_cancel", 32'(rf_wr_en), 32'd0);
        check("rst_err_clear", 32'(err), 32'd0);
        tick();
        reset = 1'b0;

        // Reset in the middle of a run, then a clean run afterwards.
        cpu_inst = 32'h1;
        drive(2'b10, 32'd0, 32'd0);
        tick();
        idle();
        tick(10);
        check("mid_count", 32'(cycle_count), 32'd10);
        reset = 1'b1;
        #1;
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_rst_count", 32'(cycle_count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        reset = 1'b0;
        drive(2'b10, 32'd0, 32'd0);
        tick();
        idle();
        tick(3);
        cpu_inst = 32'h0;
        tick();
        check("post_done", 32'(done), 32'd1);
        check("post_timed_out", 32'(timed_out), 32'd0);
        check("post_count", 32'(cycle_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/machine_preloader.md
Name: machine_preloader

Overview:
- Writer-side companion to the single-cycle machine bench flow.
- Holds the machine in reset while a command stream preloads register-file and data-memory words through dedicated write ports.
- Releases the machine on a start command, then counts executed cycles.
- Halts and flags completion on a zero instruction word or when the cycle budget expires; makes end-of-run dumps deterministic in hardware.

Parameters:
- MAX_CYCLES, 64, maximum run cycles before forced halt (must be >= 1).
- CYCLE_W, 16, width of cycle_count.
- DATA_BASE, 32'h4000, first legal data-memory word index.
- DATA_WORDS, 4, number of legal data-memory words starting at DATA_BASE.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  2  00 reg write, 01 mem write, 10 start, 11 nop.
- cmd_addr  in  32  register number (op 00) or word index (op 01).
- cmd_data  in  32  write data.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_addr  out  5
- rf_wr_data  out  32
- mem_wr_en  out  1  data-memory write strobe.
- mem_wr_addr  out  32  word index.
- mem_wr_data  out  32
- cpu_reset  out  1  reset to machine; PC only, RF and memory unaffected.
- cpu_inst  in  32  machine's current instruction word.
- done  out  1  run finished.
- timed_out  out  1  run ended by budget, not by zero instruction.
- err  out  1  sticky illegal-command flag.
- cycle_count  out  CYCLE_W  cycles spent in RUN.

Behaviour:
- Reset (async): state=LOAD; cpu_reset=1; cmd_ready=1; all strobes, done, timed_out, err=0; addr/data outputs=0; cycle_count=0.
- All outputs are registered.
- States: LOAD, RUN, HALT. cmd_ready=1 in LOAD and HALT, 0 in RUN.
- Reg write (op 00) accepted at edge k: rf_wr_en=1 for exactly the cycle after edge k, carrying cmd_addr[4:0] and cmd_data.
  - cmd_addr[31:5]!=0: no strobe; err set.
  - cmd_addr==0: silently dropped; no strobe, no err.
- Mem write (op 01): mem_wr_en pulse with the same timing, only if DATA_BASE <= cmd_addr < DATA_BASE+DATA_WORDS; otherwise no strobe and err set.
- Back-to-back accepted writes give back-to-back single-cycle strobes; no bubbles required.
- Start (op 10) accepted at edge k: from edge k, state=RUN, cpu_reset=0, cycle_count=0, done=0, timed_out=0.
- Nop (op 11): accepted, no effect.
- RUN, each edge:
  - cpu_inst==32'h0: go to HALT, done=1, timed_out=0.
  - else if cycle_count==MAX_CYCLES-1: go to HALT, done=1, timed_out=1.
  - else cycle_count+1.
  - Zero-instruction check has priority over budget expiry on the same edge.
- Entering HALT sets cpu_reset=1 on the same edge. cycle_count holds its final value.
- HALT: accepts writes exactly like LOAD (done held). An accepted start re-enters RUN as from LOAD.
- cycle_count saturates at all-ones if MAX_CYCLES exceeds its range; never wraps.
- err clears only on reset.
- Reset asserted mid-RUN or mid-strobe: immediate return to reset values; any in-flight strobe is cancelled.

Test Plan:
- Reset, then write r2=32'hFFFFFFFB, r3=1, start -> rf_wr_en pulses on two consecutive cycles with addr 2 then 3; cpu_reset falls on the start edge.
- Mem write idx 32'h4002 data 32'hDEADBEEF -> one mem_wr_en pulse with those values; idx 32'h4004 -> no strobe, err=1, err stays 1.
- Reg write to r0 -> no strobe, err stays 0; write to addr 32 -> no strobe, err=1.
- Start, cpu_inst nonzero for 5 cycles then 0 -> done=1, timed_out=0, cycle_count=5, cpu_reset=1, cmd_ready=1.
- Start, cpu_inst never 0, MAX_CYCLES=64 -> done=1 and timed_out=1 on the 64th RUN edge, cycle_count=63; with cpu_inst=0 on that same edge -> timed_out=0.
- Assert reset mid-RUN at cycle 10 -> cpu_reset=1, cycle_count=0, done=0 immediately; new start runs normally.
